// File: rtl/id_stage_buf_pkg.sv
// Shared types for the decode stage: micro-op layout, FSM states, RISC-V opcode/funct constants.
package id_pkg;

  localparam int unsigned ALUOP_W = 5;
  localparam int unsigned REG_AW  = 5;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    alu_op_e    alu_op;
    a_sel_e     a_sel;
    logic       b_imm;
    wb_sel_e    wb_sel;
    logic       rf_w;
    logic       dm_r;
    logic       dm_w;
    logic       muldiv;
    logic       sign;
    logic       word;
    logic       reads_rs2;
    logic       branch;
    logic       jump;
    logic [1:0] mem_size;
  } uop_t;

  localparam int unsigned UOP_W = $bits(uop_t);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic alu_op_e md_from_f3(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'd0:    op = ALU_MUL;
      3'd1:    op = ALU_MULH;
      3'd2:    op = ALU_MULHSU;
      3'd3:    op = ALU_MULHU;
      3'd4:    op = ALU_DIV;
      3'd5:    op = ALU_DIVU;
      3'd6:    op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_buf_if.sv
// Fetch-side, execute-side and interlock signals of the decode stage.
interface id_stage_buf_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NREG_AW = 5
);
  import id_pkg::*;

  localparam int unsigned SHW = $clog2(XLEN);

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               flush;
  logic               ex_load_valid;
  logic [NREG_AW-1:0] ex_load_rdc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  uop_t               out_uop;
  logic [NREG_AW-1:0] out_rs1c;
  logic [NREG_AW-1:0] out_rs2c;
  logic [NREG_AW-1:0] out_rdc;
  logic [XLEN-1:0]    out_imm;
  logic [SHW-1:0]     out_shamt;
  logic               hazard_stall;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, ex_load_valid, ex_load_rdc, out_ready,
    output in_ready, out_valid, out_pc, out_uop, out_rs1c, out_rs2c, out_rdc, out_imm,
           out_shamt, hazard_stall
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, ex_load_valid, ex_load_rdc, out_ready,
    input  in_ready, out_valid, out_pc, out_uop, out_rs1c, out_rs2c, out_rdc, out_imm,
           out_shamt, hazard_stall
  );
endinterface

// File: rtl/id_stage_buf_decode_core.sv
// Combinational RV32/RV64 IM decoder: raw instruction -> micro-op, register indices, immediate, shamt.
module id_decode_core
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic [31:0]       instr,
  output uop_t              uop,
  output logic [REG_AW-1:0] rs1c,
  output logic [REG_AW-1:0] rs2c,
  output logic [REG_AW-1:0] rdc,
  output logic [XLEN-1:0]   imm,
  output logic [SHW-1:0]    shamt
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       legal;
  logic       i31;
  imm_type_e  itype;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign i31    = instr[31];
  assign rdc    = instr[11:7];
  assign rs1c   = instr[19:15];
  assign rs2c   = instr[24:20];
  // On RV32 the upper shamt bit (instr[25]) is simply not part of the field.
  assign shamt  = instr[20 +: SHW];

  always_comb begin
    uop   = '0;
    itype = IMM_NONE;
    legal = 1'b0;
    case (opcode)
      OP_LUI: begin
        legal = 1'b1; uop.alu_op = ALU_PASSB; uop.a_sel = A_ZERO;
        uop.b_imm = 1'b1; uop.rf_w = 1'b1; itype = IMM_U;
      end
      OP_AUIPC: begin
        legal = 1'b1; uop.a_sel = A_PC; uop.b_imm = 1'b1; uop.rf_w = 1'b1; itype = IMM_U;
      end
      OP_JAL: begin
        legal = 1'b1; uop.a_sel = A_PC; uop.b_imm = 1'b1; uop.wb_sel = WB_PC4;
        uop.jump = 1'b1; uop.rf_w = 1'b1; itype = IMM_J;
      end
      OP_JALR: begin
        legal = (f3 == 3'd0); uop.b_imm = 1'b1; uop.wb_sel = WB_PC4;
        uop.jump = 1'b1; uop.rf_w = 1'b1; itype = IMM_I;
      end
      OP_BRANCH: begin
        legal = 1'b1; uop.reads_rs2 = 1'b1; uop.branch = 1'b1; uop.sign = ~f3[1]; itype = IMM_B;
        case (f3)
          3'd0:    uop.alu_op = ALU_EQ;
          3'd1:    uop.alu_op = ALU_NE;
          3'd4:    uop.alu_op = ALU_LT;
          3'd5:    uop.alu_op = ALU_GE;
          3'd6:    uop.alu_op = ALU_LTU;
          3'd7:    uop.alu_op = ALU_GEU;
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (IS64 && (f3 == 3'd3 || f3 == 3'd6));
        uop.b_imm = 1'b1; uop.dm_r = 1'b1; uop.rf_w = 1'b1; uop.wb_sel = WB_MEM;
        uop.sign = ~f3[2]; uop.mem_size = f3[1:0]; itype = IMM_I;
      end
      OP_STORE: begin
        legal = (f3 inside {3'd0, 3'd1, 3'd2}) || (IS64 && f3 == 3'd3);
        uop.b_imm = 1'b1; uop.dm_w = 1'b1; uop.reads_rs2 = 1'b1;
        uop.mem_size = f3[1:0]; itype = IMM_S;
      end
      OP_IMM: begin
        legal = 1'b1; uop.b_imm = 1'b1; uop.rf_w = 1'b1; itype = IMM_I;
        uop.alu_op = alu_from_f3(f3, 1'b0);
        if (f3 == 3'd1) begin
          legal = IS64 ? (instr[31:26] == 6'd0) : (f7 == F7_BASE);
        end else if (f3 == 3'd5) begin
          legal = IS64 ? (instr[31:26] == 6'd0 || instr[31:26] == 6'b010000)
                       : (f7 == F7_BASE || f7 == F7_ALT);
          uop.alu_op = alu_from_f3(f3, instr[30]);
        end
      end
      OP_OP: begin
        uop.reads_rs2 = 1'b1; uop.rf_w = 1'b1;
        if (f7 == F7_BASE) begin
          legal = 1'b1; uop.alu_op = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)) begin
          legal = 1'b1; uop.alu_op = alu_from_f3(f3, 1'b1);
        end else if (f7 == F7_MULDIV) begin
          legal = 1'b1; uop.muldiv = 1'b1; uop.alu_op = md_from_f3(f3);
        end
      end
      OP_IMM32: begin
        // Word ops only exist on RV64; on RV32 they fall through as NOPs.
        if (IS64) begin
          uop.b_imm = 1'b1; uop.rf_w = 1'b1; uop.word = 1'b1; itype = IMM_I;
          uop.alu_op = alu_from_f3(f3, instr[30] & (f3 == 3'd5));
          legal = (f3 == 3'd0) || (f3 == 3'd1 && f7 == F7_BASE) ||
                  (f3 == 3'd5 && (f7 == F7_BASE || f7 == F7_ALT));
        end
      end
      OP_OP32: begin
        if (IS64) begin
          uop.reads_rs2 = 1'b1; uop.rf_w = 1'b1; uop.word = 1'b1;
          if (f7 == F7_BASE && (f3 inside {3'd0, 3'd1, 3'd5})) begin
            legal = 1'b1; uop.alu_op = alu_from_f3(f3, 1'b0);
          end else if (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)) begin
            legal = 1'b1; uop.alu_op = alu_from_f3(f3, 1'b1);
          end else if (f7 == F7_MULDIV && (f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7})) begin
            legal = 1'b1; uop.muldiv = 1'b1; uop.alu_op = md_from_f3(f3);
          end
        end
      end
      default: ;
    endcase
    if (!legal) begin
      uop   = '0;
      itype = IMM_NONE;
    end
  end

  always_comb begin
    imm32 = '0;
    case (itype)
      IMM_I:   imm32 = {{20{i31}}, instr[31:20]};
      IMM_S:   imm32 = {{20{i31}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{i31}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'd0};
      IMM_J:   imm32 = {{12{i31}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_buf.sv
// Registered decode stage: decode at input, 2-entry head/skid buffer, flush and load-use interlock.
module id_stage_buf
  import id_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ALUOP_WIDTH = ALUOP_W,
  parameter int unsigned NREG_AW     = REG_AW
) (
  input logic         clk,
  input logic         rst,
  id_stage_buf_if.slave bus
);

  localparam int unsigned SHW = $clog2(XLEN);

  if (ALUOP_WIDTH != ALUOP_W || NREG_AW != REG_AW) begin : g_param_check
    $error("id_stage_buf: ALUOP_WIDTH/NREG_AW must match id_pkg");
  end

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [UOP_W-1:0]  uop;
    logic [REG_AW-1:0] rs1c;
    logic [REG_AW-1:0] rs2c;
    logic [REG_AW-1:0] rdc;
    logic [XLEN-1:0]   imm;
    logic [SHW-1:0]    shamt;
  } entry_t;

  state_e state_q, state_d;
  logic   in_ready_q;
  entry_t head_q, skid_q, dec_entry;
  logic   head_ld, head_from_skid, skid_ld;
  logic   acc, pop, head_valid, hazard, out_valid_c;
  uop_t   head_uop;

  uop_t              dec_uop;
  logic [REG_AW-1:0] dec_rs1c, dec_rs2c, dec_rdc;
  logic [XLEN-1:0]   dec_imm;
  logic [SHW-1:0]    dec_shamt;

  id_decode_core #(.XLEN(XLEN)) u_dec (
    .instr (bus.in_instr),
    .uop   (dec_uop),
    .rs1c  (dec_rs1c),
    .rs2c  (dec_rs2c),
    .rdc   (dec_rdc),
    .imm   (dec_imm),
    .shamt (dec_shamt)
  );

  assign dec_entry = '{pc: bus.in_pc, uop: dec_uop, rs1c: dec_rs1c, rs2c: dec_rs2c,
                       rdc: dec_rdc, imm: dec_imm, shamt: dec_shamt};

  // Load-use interlock against the head entry; x0 never interlocks.
  assign head_valid  = (state_q != EMPTY);
  assign head_uop    = uop_t'(head_q.uop);
  assign hazard      = head_valid && bus.ex_load_valid && (bus.ex_load_rdc != '0) &&
                       ((REG_AW'(bus.ex_load_rdc) == head_q.rs1c) ||
                        (head_uop.reads_rs2 && (REG_AW'(bus.ex_load_rdc) == head_q.rs2c)));
  assign out_valid_c = head_valid && !hazard;

  assign acc = bus.in_valid && in_ready_q && !bus.flush;
  assign pop = out_valid_c && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          head_ld = 1'b1;
        end
      end
      ONE: begin
        if (acc && pop) begin
          head_ld = 1'b1;
        end else if (acc) begin
          state_d = FULL;
          skid_ld = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_ld) begin
        head_q <= dec_entry;
      end else if (head_from_skid) begin
        head_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= dec_entry;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_c;
  assign bus.hazard_stall = hazard;
  assign bus.out_pc       = head_q.pc;
  assign bus.out_uop      = head_uop;
  assign bus.out_rs1c     = NREG_AW'(head_q.rs1c);
  assign bus.out_rs2c     = NREG_AW'(head_q.rs2c);
  assign bus.out_rdc      = NREG_AW'(head_q.rdc);
  assign bus.out_imm      = head_q.imm;
  assign bus.out_shamt    = head_q.shamt;

endmodule

// File: tb/tb_id_stage_buf.sv
// Directed bench for id_stage_buf with an occupancy/FIFO scoreboard model (XLEN=64) and an XLEN=32 instance.
module tb_id_stage_buf;
  import id_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_buf_if #(.XLEN(64)) b64 ();
  id_stage_buf_if #(.XLEN(32)) b32 ();

  id_stage_buf #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));
  id_stage_buf #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd2;
    logic        rf_w;
    logic        dm_r;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rd2, input logic [63:0] imm,
                              input logic rf_w, input logic dm_r);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.rd2 = rd2;
    e.imm = imm; e.rf_w = rf_w; e.dm_r = dm_r;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input exp_t e);
    b64.in_valid = v;
    b64.in_instr = instr;
    b64.in_pc    = e.pc;
    cur          = e;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, mk(64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0));
  endtask

  // One cycle: check the 64-bit DUT against the model at negedge, advance the model, step past posedge.
  task automatic tick(input string tag);
    logic exp_rdy, hv, haz, ov, acc, pop;
    @(negedge clk);
    exp_rdy = (q.size() < 2);
    hv      = (q.size() > 0);
    haz     = 1'b0;
    if (hv) begin
      haz = b64.ex_load_valid && (b64.ex_load_rdc != 5'd0) &&
            ((b64.ex_load_rdc == q[0].rs1) || (q[0].rd2 && (b64.ex_load_rdc == q[0].rs2)));
    end
    ov = hv && !haz;
    chk({tag, ".in_ready"}, 64'(b64.in_ready), 64'(exp_rdy));
    chk({tag, ".out_valid"}, 64'(b64.out_valid), 64'(ov));
    chk({tag, ".hazard"}, 64'(b64.hazard_stall), 64'(haz));
    if (ov) begin
      chk({tag, ".pc"}, b64.out_pc, q[0].pc);
      chk({tag, ".rdc"}, 64'(b64.out_rdc), 64'(q[0].rd));
      chk({tag, ".rs1c"}, 64'(b64.out_rs1c), 64'(q[0].rs1));
      chk({tag, ".rs2c"}, 64'(b64.out_rs2c), 64'(q[0].rs2));
      chk({tag, ".imm"}, b64.out_imm, q[0].imm);
      chk({tag, ".rf_w"}, 64'(b64.out_uop.rf_w), 64'(q[0].rf_w));
      chk({tag, ".dm_r"}, 64'(b64.out_uop.dm_r), 64'(q[0].dm_r));
    end
    pop = ov && b64.out_ready;
    acc = b64.in_valid && exp_rdy && !b64.flush;
    if (b64.flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    b64.flush = 1'b0; b64.ex_load_valid = 1'b0; b64.ex_load_rdc = '0; b64.out_ready = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.flush = 1'b0;
    b32.ex_load_valid = 1'b0; b32.ex_load_rdc = '0; b32.out_ready = 1'b1;

    #2;
    chk("rst.out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst.in_ready", 64'(b64.in_ready), 64'd1);
    chk("rst.out_pc", b64.out_pc, 64'd0);
    chk("rst.out_imm", b64.out_imm, 64'd0);
    chk("rst.uop", 64'(b64.out_uop), 64'd0);
    chk("rst.hazard", 64'(b64.hazard_stall), 64'd0);
    chk("rst32.out_valid", 64'(b32.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // addi x1,x0,5 with one-cycle latency; XLEN=32 lw and addiw alongside
    b64.out_ready = 1'b1;
    drive(1'b1, 32'h00500093, mk(64'h1000, 5'd0, 5'd5, 5'd1, 1'b0, 64'd5, 1'b1, 1'b0));
    b32.in_valid = 1'b1; b32.in_instr = 32'hFFC0A283; b32.in_pc = 32'h4000;
    tick("addi_acc");
    chk("lw32.out_valid", 64'(b32.out_valid), 64'd1);
    chk("lw32.imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
    chk("lw32.dm_r", 64'(b32.out_uop.dm_r), 64'd1);
    chk("lw32.rdc", 64'(b32.out_rdc), 64'd5);
    b32.in_instr = 32'h0010009B; b32.in_pc = 32'h4004;
    idle();
    tick("addi_out");
    chk("addiw32.out_valid", 64'(b32.out_valid), 64'd1);
    chk("addiw32.rf_w", 64'(b32.out_uop.rf_w), 64'd0);
    chk("addiw32.dm_w", 64'(b32.out_uop.dm_w), 64'd0);
    b32.in_valid = 1'b0;
    tick("idle0");
    chk("idle32.out_valid", 64'(b32.out_valid), 64'd0);

    // Back-pressure: three offered, two held, third refused until released
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h00100113, mk(64'h1004, 5'd0, 5'd1, 5'd2, 1'b0, 64'd1, 1'b1, 1'b0));
    tick("bp_i0");
    drive(1'b1, 32'h00200193, mk(64'h1008, 5'd0, 5'd2, 5'd3, 1'b0, 64'd2, 1'b1, 1'b0));
    tick("bp_i1");
    drive(1'b1, 32'h00300213, mk(64'h100C, 5'd0, 5'd3, 5'd4, 1'b0, 64'd3, 1'b1, 1'b0));
    tick("bp_full0");
    tick("bp_full1");
    idle();
    b64.out_ready = 1'b1;
    tick("bp_pop0");
    tick("bp_pop1");
    tick("bp_empty");

    // Load-use interlock: add x4,x3,x2 against loads to x3 then x2
    b64.ex_load_valid = 1'b1; b64.ex_load_rdc = 5'd3;
    drive(1'b1, 32'h00218233, mk(64'h2000, 5'd3, 5'd2, 5'd4, 1'b1, 64'd0, 1'b1, 1'b0));
    tick("hz_acc");
    idle();
    tick("hz_rs1");
    b64.ex_load_rdc = 5'd2;
    tick("hz_rs2");
    b64.ex_load_valid = 1'b0;
    tick("hz_issue");
    // addi x6,x1,7: rs2 field equals the load rd but addi does not read rs2
    b64.ex_load_valid = 1'b1; b64.ex_load_rdc = 5'd7;
    drive(1'b1, 32'h00708313, mk(64'h2004, 5'd1, 5'd7, 5'd6, 1'b0, 64'd7, 1'b1, 1'b0));
    tick("norw2_acc");
    idle();
    tick("norw2_out");
    // Load to x0 never interlocks, even with head reading x0
    b64.ex_load_rdc = 5'd0;
    drive(1'b1, 32'h00500093, mk(64'h2008, 5'd0, 5'd5, 5'd1, 1'b0, 64'd5, 1'b1, 1'b0));
    tick("x0_acc");
    idle();
    tick("x0_out");
    b64.ex_load_valid = 1'b0;

    // Flush from FULL with in_valid high, then flush beating an accept in ONE
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h00100113, mk(64'h3000, 5'd0, 5'd1, 5'd2, 1'b0, 64'd1, 1'b1, 1'b0));
    tick("fl_i0");
    drive(1'b1, 32'h00200193, mk(64'h3004, 5'd0, 5'd2, 5'd3, 1'b0, 64'd2, 1'b1, 1'b0));
    tick("fl_i1");
    drive(1'b1, 32'h00300213, mk(64'h3008, 5'd0, 5'd3, 5'd4, 1'b0, 64'd3, 1'b1, 1'b0));
    b64.flush = 1'b1;
    tick("fl_full");
    b64.flush = 1'b0;
    idle();
    tick("fl_after_full");
    drive(1'b1, 32'h00100113, mk(64'h3100, 5'd0, 5'd1, 5'd2, 1'b0, 64'd1, 1'b1, 1'b0));
    tick("fl_one_acc");
    drive(1'b1, 32'h00200193, mk(64'h3104, 5'd0, 5'd2, 5'd3, 1'b0, 64'd2, 1'b1, 1'b0));
    b64.flush = 1'b1;
    tick("fl_one");
    b64.flush = 1'b0;
    idle();
    tick("fl_after_one");

    // XLEN=64: lw x5,-4(x1), illegal opcode as NOP, addiw legal
    b64.out_ready = 1'b1;
    drive(1'b1, 32'hFFC0A283, mk(64'h4000, 5'd1, 5'd28, 5'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1));
    tick("lw64_acc");
    drive(1'b1, 32'hFFFFFFFF, mk(64'h4004, 5'd31, 5'd31, 5'd31, 1'b0, 64'd0, 1'b0, 1'b0));
    tick("ill_acc");
    drive(1'b1, 32'h0010009B, mk(64'h4008, 5'd0, 5'd1, 5'd1, 1'b0, 64'd1, 1'b1, 1'b0));
    tick("addiw_acc");
    idle();
    tick("addiw_out");
    tick("drain");

    // Asynchronous reset while holding an entry
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h00500093, mk(64'h5000, 5'd0, 5'd5, 5'd1, 1'b0, 64'd5, 1'b1, 1'b0));
    tick("ar_acc");
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", 64'(b64.out_valid), 64'd0);
    chk("arst.in_ready", 64'(b64.in_ready), 64'd1);
    chk("arst.out_pc", b64.out_pc, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick("ar_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
